// File: rtl/simon_input_checker_if.sv
// Bundle between the game controller / key front-end and the Simon input checker.
// The master side drives the round setup, keys and tick; the slave side reports progress.
interface simon_input_checker_if #(
    parameter int SEQ_LEN = 10
);
    logic                   start;
    logic [4*SEQ_LEN-1:0]   seq_in;
    logic [3:0]             round_len;
    logic [3:0]             keys;
    logic                   tick;
    logic                   busy;
    logic [3:0]             step_idx;
    logic                   step_ok;
    logic                   round_pass;
    logic                   round_fail;
    logic [1:0]             fail_code;

    modport master (
        output start, seq_in, round_len, keys, tick,
        input  busy, step_idx, step_ok, round_pass, round_fail, fail_code
    );

    modport slave (
        input  start, seq_in, round_len, keys, tick,
        output busy, step_idx, step_ok, round_pass, round_fail, fail_code
    );
endinterface

// File: rtl/simon_input_checker.sv
// Simon player-side checker: compares one-hot key presses against a latched sequence.
// Define SIMON_TIMEOUT_EN to add the per-step tick timeout (fail_code 10).
module simon_input_checker #(
    parameter int SEQ_LEN       = 10,
    parameter int TIMEOUT_TICKS = 5,
    parameter int TWIDTH        = 3
) (
    input logic                  CLOCK_50,
    input logic                  resetn,
    simon_input_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_RELEASE,
        WAIT_PRESS,
        CHECK
    } state_t;

    localparam logic [3:0] LEN_MAX = 4'(SEQ_LEN);

    state_t               state_q, state_d;
    logic [4*SEQ_LEN-1:0] seq_q, seq_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           key_q, key_d;
    logic [3:0]           idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 ok_q, ok_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [1:0]           code_q, code_d;
    logic [3:0]           exp_nib;
    logic                 expire;

`ifdef SIMON_TIMEOUT_EN
    logic [TWIDTH-1:0] tcnt_q, tcnt_d;

    // Counter sits at zero outside the waiting states, so each step starts fresh.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == IDLE || state_q == CHECK)
            tcnt_d = '0;
        else if (bus.tick)
            tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) tcnt_q <= '0;
        else         tcnt_q <= tcnt_d;
    end

    assign expire = bus.tick && (tcnt_q == TWIDTH'(TIMEOUT_TICKS - 1));
`else
    assign expire = 1'b0;
`endif

    assign exp_nib = seq_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        len_d   = len_q;
        key_d   = key_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        code_d  = code_q;
        ok_d    = 1'b0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seq_d   = bus.seq_in;
                    if (bus.round_len == 4'd0)
                        len_d = 4'd1;
                    else if (bus.round_len > LEN_MAX)
                        len_d = LEN_MAX;
                    else
                        len_d = bus.round_len;
                    idx_d   = 4'd0;
                    code_d  = 2'b00;
                    busy_d  = 1'b1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (expire) begin
                    fail_d  = 1'b1;
                    code_d  = 2'b10;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.keys == 4'd0) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // A press beats a timeout tick landing in the same cycle.
                if (bus.keys != 4'd0) begin
                    key_d   = bus.keys;
                    state_d = CHECK;
                end else if (expire) begin
                    fail_d  = 1'b1;
                    code_d  = 2'b10;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!$onehot(exp_nib)) begin
                    fail_d = 1'b1;
                    code_d = 2'b11;
                end else if (key_q == exp_nib) begin
                    ok_d = 1'b1;
                    if (idx_q == len_q - 4'd1) begin
                        pass_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        busy_d  = 1'b1;
                        state_d = WAIT_RELEASE;
                    end
                end else begin
                    fail_d = 1'b1;
                    code_d = 2'b01;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ok_q    <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            ok_q    <= ok_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.step_idx   = idx_q;
    assign bus.step_ok    = ok_q;
    assign bus.round_pass = pass_q;
    assign bus.round_fail = fail_q;
    assign bus.fail_code  = code_q;
endmodule
